// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, funct encodings, immediate formats and
// the decoded-instruction record carried by the decode stage output register.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SR  = 3'b101;

  // Branch compare code driven for non-branches; the compare unit yields 0 for it.
  localparam logic [2:0] BR_NOP = 3'b010;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] target;
    logic [31:0] store_data;
    logic [31:0] pc;
    logic [2:0]  alu_op;
    logic [2:0]  branch_op;
    logic        sub;
    logic        arith_shift;
    logic        is_branch;
    logic        is_jump;
    logic        is_load;
    logic        is_store;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } dec_t;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    case (opcode)
      OPC_LUI, OPC_AUIPC:                    return FMT_U;
      OPC_JAL:                               return FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM:        return FMT_I;
      OPC_BRANCH:                            return FMT_B;
      OPC_STORE:                             return FMT_S;
      default:                               return FMT_R;
    endcase
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_e fmt);
    case (fmt)
      FMT_I:   return {{20{instr[31]}}, instr[31:20]};
      FMT_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   return {instr[31:12], 12'b0};
      FMT_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/rv_regfile.sv
// 32x32 integer register file: two combinational read ports, one write port,
// x0 hardwired to zero, optional same-cycle write-to-read forwarding.
module rv_regfile #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        we,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] mem [32];

  // NOTE: the storage array has no reset; clearing 32 words costs a reset tree for
  // nothing, since software never reads a register before writing it and x0 is forced below.
  always_ff @(posedge clk) begin
    if (we && (wr_addr != 5'd0)) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != 5'd0)
      rs1_data = (BYPASS && we && (wr_addr == rs1_addr)) ? wr_data : mem[rs1_addr];
    if (rs2_addr != 5'd0)
      rs2_data = (BYPASS && we && (wr_addr == rs2_addr)) ? wr_data : mem[rs2_addr];
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode/operand stage: decodes the fetched instruction, reads operands and
// holds ALU-ready operands and control in a single flushable valid/ready pipeline register.
module decode_stage
  import rv_pkg::*;
#(
  parameter bit WB_BYPASS   = 1'b1,
  parameter bit ZERO_ON_NOP = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic        i_flush,
  input  logic        i_wb_en,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [2:0]  o_alu_op,
  output logic        o_sub,
  output logic        o_arith_shift,
  output logic [2:0]  o_branch_op,
  output logic        o_is_branch,
  output logic        o_is_jump,
  output logic        o_is_load,
  output logic        o_is_store,
  output logic [31:0] o_target,
  output logic [31:0] o_store_data,
  output logic [4:0]  o_rd,
  output logic        o_rd_we,
  output logic [31:0] o_pc,
  output logic        o_illegal
);

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm, rs1_val, rs2_val;
  logic        accept, rd_wr, ill, valid_q;
  dec_t        dec, out_q;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];
  assign imm    = imm_gen(i_instr, imm_fmt(opcode));

  assign o_ready = !valid_q || i_ready;
  assign accept  = i_valid && o_ready;

  rv_regfile #(.BYPASS(WB_BYPASS)) u_regfile (
    .clk      (i_clk),
    .rs1_addr (i_instr[19:15]),
    .rs2_addr (i_instr[24:20]),
    .rs1_data (rs1_val),
    .rs2_data (rs2_val),
    .we       (i_wb_en),
    .wr_addr  (i_wb_rd),
    .wr_data  (i_wb_data)
  );

  // NOTE: every field gets a default before the case so no path leaves one unassigned
  // (an unassigned path would infer a latch).
  always_comb begin
    dec            = '0;
    dec.pc         = i_pc;
    dec.rd         = i_instr[11:7];
    dec.store_data = rs2_val;
    dec.alu_op     = ALU_ADD;
    dec.branch_op  = BR_NOP;
    rd_wr          = 1'b1;
    ill            = 1'b0;
    case (opcode)
      OPC_LUI:   dec.b = imm;
      OPC_AUIPC: begin dec.a = i_pc; dec.b = imm; end
      OPC_JAL: begin
        dec.a = i_pc; dec.b = 32'd4; dec.target = i_pc + imm; dec.is_jump = 1'b1;
      end
      OPC_JALR: begin
        dec.a = i_pc; dec.b = 32'd4; dec.target = (rs1_val + imm) & ~32'd1; dec.is_jump = 1'b1;
      end
      OPC_BRANCH: begin
        dec.a = rs1_val; dec.b = rs2_val; dec.branch_op = funct3;
        dec.target = i_pc + imm; dec.is_branch = 1'b1;
        rd_wr = 1'b0;
        ill   = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD:  begin dec.a = rs1_val; dec.b = imm; dec.is_load = 1'b1; end
      OPC_STORE: begin dec.a = rs1_val; dec.b = imm; dec.is_store = 1'b1; rd_wr = 1'b0; end
      OPC_OP_IMM: begin
        dec.a = rs1_val; dec.b = imm; dec.alu_op = funct3;
        // Shifts carry the 5-bit shamt; the upper immediate bits are a funct7 selector.
        if (funct3 == ALU_SLL || funct3 == ALU_SR) begin
          dec.b           = {27'd0, i_instr[24:20]};
          dec.arith_shift = (funct3 == ALU_SR) && i_instr[30];
          ill = !((funct7 == F7_BASE) || (funct3 == ALU_SR && funct7 == F7_ALT));
        end
      end
      OPC_OP: begin
        dec.a = rs1_val; dec.b = rs2_val; dec.alu_op = funct3;
        dec.sub         = (funct3 == ALU_ADD) && i_instr[30];
        dec.arith_shift = (funct3 == ALU_SR) && i_instr[30];
        ill = !((funct7 == F7_BASE) ||
                (funct7 == F7_ALT && (funct3 == ALU_ADD || funct3 == ALU_SR)));
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec.a           = '0;
      dec.b           = '0;
      dec.target      = '0;
      dec.alu_op      = ALU_ADD;
      dec.branch_op   = BR_NOP;
      dec.sub         = 1'b0;
      dec.arith_shift = 1'b0;
      dec.is_branch   = 1'b0;
      dec.is_jump     = 1'b0;
      dec.is_load     = 1'b0;
      dec.is_store    = 1'b0;
    end
    dec.illegal = ill;
    dec.rd_we   = rd_wr && !ill && (dec.rd != 5'd0);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      out_q   <= dec;
    end else if (i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_valid       = valid_q;
  assign o_a           = (ZERO_ON_NOP && !valid_q) ? '0 : out_q.a;
  assign o_b           = (ZERO_ON_NOP && !valid_q) ? '0 : out_q.b;
  assign o_alu_op      = out_q.alu_op;
  assign o_sub         = out_q.sub;
  assign o_arith_shift = out_q.arith_shift;
  assign o_branch_op   = out_q.branch_op;
  assign o_is_branch   = out_q.is_branch;
  assign o_is_jump     = out_q.is_jump;
  assign o_is_load     = out_q.is_load;
  assign o_is_store    = out_q.is_store;
  assign o_target      = out_q.target;
  assign o_store_data  = out_q.store_data;
  assign o_rd          = out_q.rd;
  assign o_rd_we       = out_q.rd_we;
  assign o_pc          = out_q.pc;
  assign o_illegal     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized instruction
// streams, both compared against an architectural decode model and a shadow register file.
module tb_decode_stage;

  typedef struct packed {
    logic        valid, illegal, is_branch, is_jump, is_load, is_store, rd_we;
    logic [4:0]  rd;
    logic [2:0]  alu_op;
    logic        sub, arith_shift;
    logic [2:0]  branch_op;
    logic [31:0] a, b, target, store_data, pc;
  } obs_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_valid = 1'b0, i_flush = 1'b0, i_ready = 1'b1, i_wb_en = 1'b0;
  logic [31:0] i_instr = '0, i_pc = '0, i_wb_data = '0;
  logic [4:0]  i_wb_rd = '0;

  logic        o_ready, o_valid, o_sub, o_arith_shift, o_is_branch, o_is_jump, o_is_load;
  logic        o_is_store, o_rd_we, o_illegal;
  logic [31:0] o_a, o_b, o_target, o_store_data, o_pc;
  logic [2:0]  o_alu_op, o_branch_op;
  logic [4:0]  o_rd;
  logic        n_ready, n_valid, n_sub, n_arith_shift, n_is_branch, n_is_jump, n_is_load;
  logic        n_is_store, n_rd_we, n_illegal;
  logic [31:0] n_a, n_b, n_target, n_store_data, n_pc;
  logic [2:0]  n_alu_op, n_branch_op;
  logic [4:0]  n_rd;

  obs_t act_bp, act_nb;
  logic [31:0] rf [32];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  decode_stage #(.WB_BYPASS(1'b1), .ZERO_ON_NOP(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_instr(i_instr),
    .i_pc(i_pc), .i_flush(i_flush), .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_a(o_a), .o_b(o_b), .o_alu_op(o_alu_op),
    .o_sub(o_sub), .o_arith_shift(o_arith_shift), .o_branch_op(o_branch_op),
    .o_is_branch(o_is_branch), .o_is_jump(o_is_jump), .o_is_load(o_is_load),
    .o_is_store(o_is_store), .o_target(o_target), .o_store_data(o_store_data), .o_rd(o_rd),
    .o_rd_we(o_rd_we), .o_pc(o_pc), .o_illegal(o_illegal));

  decode_stage #(.WB_BYPASS(1'b0), .ZERO_ON_NOP(1'b1)) dut_nb (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(n_ready), .i_instr(i_instr),
    .i_pc(i_pc), .i_flush(i_flush), .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .o_valid(n_valid), .i_ready(i_ready), .o_a(n_a), .o_b(n_b), .o_alu_op(n_alu_op),
    .o_sub(n_sub), .o_arith_shift(n_arith_shift), .o_branch_op(n_branch_op),
    .o_is_branch(n_is_branch), .o_is_jump(n_is_jump), .o_is_load(n_is_load),
    .o_is_store(n_is_store), .o_target(n_target), .o_store_data(n_store_data), .o_rd(n_rd),
    .o_rd_we(n_rd_we), .o_pc(n_pc), .o_illegal(n_illegal));

  assign act_bp = {o_valid, o_illegal, o_is_branch, o_is_jump, o_is_load, o_is_store, o_rd_we,
                   o_rd, o_alu_op, o_sub, o_arith_shift, o_branch_op,
                   o_a, o_b, o_target, o_store_data, o_pc};
  assign act_nb = {n_valid, n_illegal, n_is_branch, n_is_jump, n_is_load, n_is_store, n_rd_we,
                   n_rd, n_alu_op, n_sub, n_arith_shift, n_branch_op,
                   n_a, n_b, n_target, n_store_data, n_pc};

  // Architectural decode of one instruction given the operand values seen at accept.
  function automatic obs_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2);
    obs_t        e  = '0;
    logic [6:0]  f7 = ins[31:25];
    logic [2:0]  f3 = ins[14:12];
    logic [31:0] ii = 32'($signed(ins[31:20]));
    logic [31:0] si = 32'($signed({ins[31:25], ins[11:7]}));
    logic [31:0] bi = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    logic [31:0] ji = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    logic [31:0] ui = ins & 32'hFFFF_F000;
    e.valid = 1'b1; e.pc = pc; e.rd = ins[11:7]; e.store_data = r2; e.branch_op = 3'b010;
    case (ins[6:0])
      7'h37: e.b = ui;
      7'h17: begin e.a = pc; e.b = ui; end
      7'h6F: begin e.a = pc; e.b = 4; e.target = pc + ji; e.is_jump = 1'b1; end
      7'h67: begin e.a = pc; e.b = 4; e.target = (r1 + ii) & 32'hFFFF_FFFE; e.is_jump = 1'b1; end
      7'h63: if (f3 == 3'd2 || f3 == 3'd3) e.illegal = 1'b1;
             else begin
               e.a = r1; e.b = r2; e.branch_op = f3; e.target = pc + bi; e.is_branch = 1'b1;
             end
      7'h03: begin e.a = r1; e.b = ii; e.is_load = 1'b1; end
      7'h23: begin e.a = r1; e.b = si; e.is_store = 1'b1; end
      7'h13: begin
        e.a = r1; e.b = ii; e.alu_op = f3;
        if (f3 == 3'd1) begin e.b = 32'(ins[24:20]); e.illegal = (f7 != 7'h00); end
        if (f3 == 3'd5) begin
          e.b = 32'(ins[24:20]); e.arith_shift = ins[30];
          e.illegal = (f7 != 7'h00) && (f7 != 7'h20);
        end
      end
      7'h33: begin
        e.a = r1; e.b = r2; e.alu_op = f3;
        e.sub = (f3 == 3'd0) && ins[30];
        e.arith_shift = (f3 == 3'd5) && ins[30];
        e.illegal = ((f7 != 7'h00) && (f7 != 7'h20)) || (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5);
      end
      default: e.illegal = 1'b1;
    endcase
    e.rd_we = !e.illegal && ins[6:0] != 7'h23 && ins[6:0] != 7'h63 && e.rd != 5'd0;
    return e;
  endfunction

  // Blank the fields whose value carries no meaning for the reference instruction r.
  function automatic obs_t mask(input obs_t o, input obs_t r);
    obs_t m = o;
    if (r.illegal) begin
      m.a = '0; m.b = '0; m.target = '0; m.store_data = '0; m.alu_op = '0;
      m.sub = 1'b0; m.arith_shift = 1'b0; m.branch_op = '0;
    end
    if (!r.rd_we) m.rd = '0;
    if (!(r.is_branch || r.is_jump)) m.target = '0;
    if (r.is_branch) m.alu_op = '0;
    return m;
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
    i_wb_en = 1'b1; i_wb_rd = rd; i_wb_data = data;
    tick();
    i_wb_en = 1'b0;
    if (rd != 5'd0) rf[rd] = data;
  endtask

  // Present one instruction (optionally with a concurrent writeback) and accept it.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic we,
                       input logic [4:0] wrd, input logic [31:0] wd,
                       output obs_t e_bp, output obs_t e_nb);
    logic [31:0] r1, r2, b1, b2;
    r1 = rf[ins[19:15]];
    r2 = rf[ins[24:20]];
    b1 = (we && wrd != 5'd0 && wrd == ins[19:15]) ? wd : r1;
    b2 = (we && wrd != 5'd0 && wrd == ins[24:20]) ? wd : r2;
    e_bp = model(ins, pc, b1, b2);
    e_nb = model(ins, pc, r1, r2);
    i_valid = 1'b1; i_instr = ins; i_pc = pc; i_ready = 1'b1;
    i_wb_en = we; i_wb_rd = wrd; i_wb_data = wd;
    tick();
    if (we && wrd != 5'd0) rf[wrd] = wd;
    i_valid = 1'b0; i_wb_en = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) rf[i] = '0;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (act_bp !== obs_t'(0) || o_ready !== 1'b1) begin
      failures++; $display("FAIL reset_state got=%h ready=%b exp=0 ready=1", act_bp, o_ready);
    end
    checks++;
    if (act_nb !== obs_t'(0) || n_ready !== 1'b1) begin
      failures++; $display("FAIL reset_state_nb got=%h ready=%b exp=0 ready=1", act_nb, n_ready);
    end
    for (int r = 1; r < 32; r++) wb_write(5'(r), $urandom);
  endtask

  task automatic test_alu_ops();
    obs_t e, en;
    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    issue(enc_i(12'hFFF, 5'd1, 3'd0, 5'd3, 7'h13), 32'h40, 1'b0, 5'd0, 32'd0, e, en);
    checks++;
    if (mask(act_bp, e) !== mask(e, e)) begin
      failures++; $display("FAIL addi got=%h exp=%h", act_bp, e);
    end
    checks++;
    if ({o_a, o_b, o_alu_op, o_sub, o_rd, o_rd_we} !== {32'd5, 32'hFFFF_FFFF, 3'd0, 1'b0, 5'd3, 1'b1}) begin
      failures++; $display("FAIL addi_fields a=%h b=%h op=%h sub=%b rd=%0d we=%b exp a=5 b=ffffffff op=0 sub=0 rd=3 we=1",
                           o_a, o_b, o_alu_op, o_sub, o_rd, o_rd_we);
    end
    issue(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h44, 1'b0, 5'd0, 32'd0, e, en);
    checks++;
    if (mask(act_bp, e) !== mask(e, e) || {o_sub, o_alu_op} !== 4'b1_000) begin
      failures++; $display("FAIL sub got=%h exp=%h", act_bp, e);
    end
    issue(enc_r(7'h20, 5'd3, 5'd1, 3'd5, 5'd4, 7'h13), 32'h48, 1'b0, 5'd0, 32'd0, e, en);
    checks++;
    if (mask(act_bp, e) !== mask(e, e) || {o_alu_op, o_arith_shift, o_b} !== {3'b101, 1'b1, 32'd3}) begin
      failures++; $display("FAIL srai got=%h exp=%h", act_bp, e);
    end
  endtask

  task automatic test_branch_jump();
    obs_t e, en;
    issue(enc_b(-13'sd8, 5'd2, 5'd1, 3'd0), 32'h100, 1'b0, 5'd0, 32'd0, e, en);
    checks++;
    if (mask(act_bp, e) !== mask(e, e) ||
        {o_is_branch, o_branch_op, o_target, o_rd_we} !== {1'b1, 3'b000, 32'hF8, 1'b0}) begin
      failures++; $display("FAIL beq got=%h exp=%h", act_bp, e);
    end
    wb_write(5'd2, 32'h1001);
    issue(enc_i(12'h000, 5'd2, 3'd0, 5'd1, 7'h67), 32'h200, 1'b0, 5'd0, 32'd0, e, en);
    checks++;
    if (mask(act_bp, e) !== mask(e, e) ||
        {o_target, o_a, o_b, o_is_jump} !== {32'h1000, 32'h200, 32'd4, 1'b1}) begin
      failures++; $display("FAIL jalr got=%h exp=%h", act_bp, e);
    end
    rf[1] = 32'd5;
    wb_write(5'd1, 32'd5);
  endtask

  task automatic test_stall_flush();
    obs_t e, en;
    issue(enc_i(12'h010, 5'd1, 3'd0, 5'd8, 7'h03), 32'h300, 1'b0, 5'd0, 32'd0, e, en);
    i_ready = 1'b0; i_valid = 1'b1; i_instr = enc_i(12'h001, 5'd2, 3'd0, 5'd9, 7'h13); i_pc = 32'h304;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (mask(act_bp, e) !== mask(e, e) || o_ready !== 1'b0) begin
        failures++; $display("FAIL stall_hold%0d got=%h ready=%b exp=%h ready=0", c, act_bp, o_ready, e);
      end
    end
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    checks++;
    if (o_valid !== 1'b0 || n_valid !== 1'b0) begin
      failures++; $display("FAIL flush got valid=%b/%b exp 0", o_valid, n_valid);
    end
    tick();
    checks++;
    if ({o_valid, o_a, o_b} !== 65'd0) begin
      failures++; $display("FAIL flush_discard got valid=%b a=%h b=%h exp 0", o_valid, o_a, o_b);
    end
  endtask

  task automatic test_bypass();
    obs_t e, en;
    issue(enc_i(12'h000, 5'd1, 3'd0, 5'd5, 7'h13), 32'h400, 1'b1, 5'd1, 32'd9, e, en);
    checks++;
    if (mask(act_bp, e) !== mask(e, e) || o_a !== 32'd9) begin
      failures++; $display("FAIL bypass_on got=%h exp=%h", act_bp, e);
    end
    checks++;
    if (mask(act_nb, en) !== mask(en, en) || n_a !== 32'd5) begin
      failures++; $display("FAIL bypass_off got=%h exp=%h", act_nb, en);
    end
    issue(enc_i(12'h000, 5'd0, 3'd0, 5'd6, 7'h13), 32'h404, 1'b1, 5'd0, 32'hDEAD, e, en);
    checks++;
    if (o_a !== 32'd0 || n_a !== 32'd0 || mask(act_bp, e) !== mask(e, e)) begin
      failures++; $display("FAIL wb_x0 got a=%h/%h exp 0", o_a, n_a);
    end
  endtask

  task automatic test_illegal();
    obs_t e, en;
    issue({25'h0AB_CDEF, 7'h7F}, 32'h500, 1'b0, 5'd0, 32'd0, e, en);
    checks++;
    if (mask(act_bp, e) !== mask(e, e) || {o_valid, o_illegal, o_rd_we} !== 3'b110) begin
      failures++; $display("FAIL illegal_opc got=%h exp=%h", act_bp, e);
    end
    issue(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h504, 1'b0, 5'd0, 32'd0, e, en);
    checks++;
    if (mask(act_bp, e) !== mask(e, e) ||
        {o_illegal, o_rd_we, o_is_branch, o_is_jump, o_is_load, o_is_store} !== 6'b10_0000) begin
      failures++; $display("FAIL illegal_f7 got=%h exp=%h", act_bp, e);
    end
  endtask

  task automatic test_random();
    logic [6:0]  opcs [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    logic [31:0] ins;
    obs_t        e, en;
    int          sel;
    for (int k = 0; k < 300; k++) begin
      ins = $urandom;
      sel = $urandom_range(0, 10);
      if (sel < 9) ins[6:0] = opcs[sel];
      if ((ins[6:0] == 7'h33 || ins[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
        ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      issue(ins, $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0) ? ins[19:15] : 5'($urandom), $urandom, e, en);
      checks++;
      if (mask(act_bp, e) !== mask(e, e)) begin
        failures++; $display("FAIL rand%0d ins=%h got=%h exp=%h", k, ins, act_bp, e);
      end
      checks++;
      if (mask(act_nb, en) !== mask(en, en)) begin
        failures++; $display("FAIL rand_nb%0d ins=%h got=%h exp=%h", k, ins, act_nb, en);
      end
    end
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_b !== 32'd0) begin
      failures++; $display("FAIL drain got valid=%b b=%h exp 0", o_valid, o_b);
    end
  endtask

  task automatic test_reset_stall();
    obs_t e, en;
    issue(enc_i(12'h001, 5'd1, 3'd0, 5'd7, 7'h13), 32'h600, 1'b0, 5'd0, 32'd0, e, en);
    i_ready = 1'b0; i_valid = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (act_bp !== obs_t'(0) || act_nb !== obs_t'(0)) begin
      failures++; $display("FAIL async_reset got=%h/%h exp=0", act_bp, act_nb);
    end
    @(negedge clk);
    i_valid = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      failures++; $display("FAIL post_reset got valid=%b ready=%b exp valid=0 ready=1", o_valid, o_ready);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_branch_jump();
    test_stall_flush();
    test_bypass();
    test_illegal();
    test_random();
    test_reset_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
